// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types for the ALU operation sequencer
//
// Purpose: ALU select encoding and sequencer FSM state encoding.
// Ports:   none (package).

package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ZERO  = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_PASSA = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_OR    = 3'd5,
    ALU_AND   = 3'd6,
    ALU_INCA  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_regfile.sv
// rtl/seq_regfile.sv - NREGS x WIDTH register file, register 0 hardwired to zero
//
// Purpose: operand storage for the sequencer; two asynchronous read ports,
//          one synchronous write port, asynchronous active-low clear.
// Ports:
//   clk      in   1      write clock
//   rst_n    in   1      asynchronous active-low clear of all entries
//   raddr_a  in   RW     read port A address
//   rdata_a  out  WIDTH  read port A data (combinational)
//   raddr_b  in   RW     read port B address
//   rdata_b  out  WIDTH  read port B data (combinational)
//   we       in   1      write enable
//   waddr    in   RW     write address (writes to 0 are discarded)
//   wdata    in   WIDTH  write data

module seq_regfile #(
  parameter  int WIDTH = 3,
  parameter  int NREGS = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [RW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but the read mux still forces zero so the
  // constant does not depend on the write guard above.
  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command-side initiator for the 3-op-select combinational ALU
//
// Purpose: accepts an ALU command, fetches operands from the local register
//          file, presents Sel/A/B to the external ALU, captures Q one cycle
//          later, writes it back and returns it on the response channel.
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   CmdValid/CmdReady       command handshake
//   CmdOp, CmdRa, CmdRb,    ALU select, source A, source B, destination,
//   CmdRd, CmdImmEn, CmdImm immediate-enable and immediate B operand
//   AluSel, AluA, AluB      registered ALU inputs
//   AluQ                    combinational ALU result
//   RspValid/RspReady       response handshake
//   RspData, RspRd          captured result and its destination register

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int NREGS = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [RW-1:0]    CmdRa,
  input  logic [RW-1:0]    CmdRb,
  input  logic [RW-1:0]    CmdRd,
  input  logic             CmdImmEn,
  input  logic [WIDTH-1:0] CmdImm,
  output logic [2:0]       AluSel,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluQ,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic [RW-1:0]    RspRd
);

  seq_state_e       state_q, state_d;
  alu_op_e          sel_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]    rd_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [RW-1:0]    rsp_rd_q;
  logic [WIDTH-1:0] rf_a, rf_b;
  logic             accept;
  logic             rf_we;

  seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .raddr_a (CmdRa),
    .rdata_a (rf_a),
    .raddr_b (CmdRb),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (AluQ)
  );

  assign accept = CmdValid && (state_q == S_IDLE);
  // Write-back happens on the EXEC->RESP edge, so the register file is
  // already updated by the time CmdReady returns: no forwarding needed.
  assign rf_we  = (state_q == S_EXEC);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (CmdValid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (RspReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers only load on accept, so the ALU inputs hold their
  // last value while the sequencer is idle or waiting on the consumer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_q <= ALU_ZERO;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      sel_q <= alu_op_e'(CmdOp);
      a_q   <= rf_a;
      b_q   <= CmdImmEn ? CmdImm : rf_b;
      rd_q  <= CmdRd;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
    end else if (state_q == S_EXEC) begin
      rsp_data_q <= AluQ;
      rsp_rd_q   <= rd_q;
    end
  end

  assign CmdReady = (state_q == S_IDLE);
  assign RspValid = (state_q == S_RESP);
  assign AluSel   = sel_q;
  assign AluA     = a_q;
  assign AluB     = b_q;
  assign RspData  = rsp_data_q;
  assign RspRd    = rsp_rd_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer

module tb_alu_op_sequencer;

  localparam int WIDTH = 3;
  localparam int NREGS = 8;
  localparam int RW    = 3;
  localparam int MODV  = 8;

  localparam int OP_ZERO = 0, OP_ADD = 1, OP_SUB = 2, OP_PASSA = 3;
  localparam int OP_XOR = 4, OP_OR = 5, OP_AND = 6, OP_INCA = 7;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             CmdValid = 1'b0;
  logic             CmdReady;
  logic [2:0]       CmdOp = '0;
  logic [RW-1:0]    CmdRa = '0;
  logic [RW-1:0]    CmdRb = '0;
  logic [RW-1:0]    CmdRd = '0;
  logic             CmdImmEn = 1'b0;
  logic [WIDTH-1:0] CmdImm = '0;
  logic [2:0]       AluSel;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [WIDTH-1:0] AluQ;
  logic             RspValid;
  logic             RspReady = 1'b0;
  logic [WIDTH-1:0] RspData;
  logic [RW-1:0]    RspRd;

  int checks = 0;
  int errors = 0;
  int mrf[NREGS];

  always #5 Clk = ~Clk;

  // External combinational ALU: 8-way mux on select.
  always_comb begin
    case (AluSel)
      3'd0:    AluQ = '0;
      3'd1:    AluQ = AluA + AluB;
      3'd2:    AluQ = AluA - AluB;
      3'd3:    AluQ = AluA;
      3'd4:    AluQ = AluA ^ AluB;
      3'd5:    AluQ = AluA | AluB;
      3'd6:    AluQ = AluA & AluB;
      default: AluQ = AluA + 3'd1;
    endcase
  end

  alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdRa    (CmdRa),
    .CmdRb    (CmdRb),
    .CmdRd    (CmdRd),
    .CmdImmEn (CmdImmEn),
    .CmdImm   (CmdImm),
    .AluSel   (AluSel),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluQ     (AluQ),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspRd    (RspRd)
  );

  task automatic scramble_cmd_fields();
    CmdOp    = 3'($urandom_range(0, 7));
    CmdRa    = RW'($urandom_range(0, NREGS - 1));
    CmdRb    = RW'($urandom_range(0, NREGS - 1));
    CmdRd    = RW'($urandom_range(0, NREGS - 1));
    CmdImmEn = 1'($urandom_range(0, 1));
    CmdImm   = WIDTH'($urandom_range(0, MODV - 1));
  endtask

  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      OP_ZERO:  return 0;
      OP_ADD:   return (a + b) % MODV;
      OP_SUB:   return (a - b + MODV) % MODV;
      OP_PASSA: return a;
      OP_XOR:   return a ^ b;
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      default:  return (a + 1) % MODV;
    endcase
  endfunction

  // Full command transaction; stall = cycles RspReady is held low in RESP.
  task automatic do_cmd(input int op, input int ra, input int rb, input int rd,
                        input int immen, input int imm, input int stall, output int q);
    int a, b;
    a = (ra == 0) ? 0 : mrf[ra];
    b = (immen != 0) ? imm : ((rb == 0) ? 0 : mrf[rb]);
    q = ref_result(op, a, b);

    @(negedge Clk);
    checks++;
    if (CmdReady !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b want 1", CmdReady);
    end
    CmdValid = 1'b1; CmdOp = 3'(op); CmdRa = RW'(ra); CmdRb = RW'(rb);
    CmdRd = RW'(rd); CmdImmEn = 1'(immen); CmdImm = WIDTH'(imm);
    RspReady = 1'b0;

    @(negedge Clk);
    CmdValid = 1'b0;
    scramble_cmd_fields();
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b0) begin
      errors++; $display("FAIL exec_flags: valid %b ready %b want 0 0", RspValid, CmdReady);
    end
    checks++;
    if (AluSel !== 3'(op) || AluA !== WIDTH'(a) || AluB !== WIDTH'(b)) begin
      errors++;
      $display("FAIL alu_inputs: sel %0d a %0d b %0d want %0d %0d %0d", AluSel, AluA, AluB, op, a, b);
    end

    @(negedge Clk);
    checks++;
    if (RspValid !== 1'b1 || RspData !== WIDTH'(q) || RspRd !== RW'(rd)) begin
      errors++;
      $display("FAIL response: valid %b data %0d rd %0d want 1 %0d %0d", RspValid, RspData, RspRd, q, rd);
    end

    for (int s = 0; s < stall; s++) begin
      CmdValid = 1'($urandom_range(0, 1));
      scramble_cmd_fields();
      @(negedge Clk);
      checks++;
      if (RspValid !== 1'b1 || RspData !== WIDTH'(q) || RspRd !== RW'(rd) ||
          CmdReady !== 1'b0 || AluSel !== 3'(op)) begin
        errors++;
        $display("FAIL stall_hold: valid %b data %0d rd %0d ready %b sel %0d want 1 %0d %0d 0 %0d",
                 RspValid, RspData, RspRd, CmdReady, AluSel, q, rd, op);
      end
    end

    CmdValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b1) begin
      errors++; $display("FAIL rsp_done: valid %b ready %b want 0 1", RspValid, CmdReady);
    end
    if (rd != 0) mrf[rd] = q;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) mrf[i] = 0;
  endtask

  task automatic check_all_regs_zero();
    int q;
    for (int i = 0; i < NREGS; i++) begin
      do_cmd(OP_PASSA, i, 0, 0, 0, 0, 0, q);
      checks++;
      if (RspData !== 3'd0) begin
        errors++; $display("FAIL reg_cleared r%0d: got %0d want 0", i, RspData);
      end
    end
  endtask

  task automatic test_reset();
    int q;
    clear_model();
    repeat (3) @(negedge Clk);
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b1 || AluSel !== 3'd0 || AluA !== 3'd0 ||
        AluB !== 3'd0 || RspData !== 3'd0 || RspRd !== 3'd0) begin
      errors++; $display("FAIL reset_state: valid %b ready %b sel %0d a %0d b %0d data %0d rd %0d",
                         RspValid, CmdReady, AluSel, AluA, AluB, RspData, RspRd);
    end
    Reset_n = 1'b1;
    for (int i = 1; i < NREGS; i++) do_cmd(OP_ADD, 0, 0, i, 1, $urandom_range(1, 7), 0, q);
    // Park in RESP with non-zero state, then reset between edges.
    @(negedge Clk);
    CmdValid = 1'b1; CmdOp = 3'd4; CmdRa = 3'd3; CmdRb = 3'd5; CmdRd = 3'd6; CmdImmEn = 1'b0;
    @(negedge Clk);
    CmdValid = 1'b0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b1 || AluSel !== 3'd0 || AluA !== 3'd0 ||
        AluB !== 3'd0 || RspData !== 3'd0 || RspRd !== 3'd0) begin
      errors++; $display("FAIL midrun_reset: valid %b ready %b sel %0d a %0d b %0d data %0d rd %0d",
                         RspValid, CmdReady, AluSel, AluA, AluB, RspData, RspRd);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    clear_model();
    check_all_regs_zero();
  endtask

  task automatic test_basic();
    int q;
    do_cmd(OP_ADD, 0, 0, 1, 1, 5, 0, q);
    checks++;
    if (RspData !== 3'b101 || q != 5) begin
      errors++; $display("FAIL add_imm: got %0d want 5", RspData);
    end
    do_cmd(OP_PASSA, 1, 0, 2, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'b101) begin
      errors++; $display("FAIL passa_r1: got %0d want 5", RspData);
    end
  endtask

  task automatic test_wrap();
    int q;
    do_cmd(OP_ADD, 0, 0, 1, 1, 5, 0, q);
    do_cmd(OP_ADD, 0, 0, 2, 1, 2, 0, q);
    do_cmd(OP_SUB, 2, 1, 3, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'b101) begin
      errors++; $display("FAIL sub_wrap: got %0d want 5", RspData);
    end
    do_cmd(OP_ADD, 0, 0, 4, 1, 7, 0, q);
    do_cmd(OP_INCA, 4, 0, 4, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'b000) begin
      errors++; $display("FAIL inca_wrap: got %0d want 0", RspData);
    end
  endtask

  task automatic test_backpressure();
    int q;
    do_cmd(OP_OR, 1, 2, 5, 0, 0, 5, q);
    do_cmd(OP_PASSA, 5, 0, 0, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'(mrf[5])) begin
      errors++; $display("FAIL bp_no_extra_cmd: got %0d want %0d", RspData, mrf[5]);
    end
  endtask

  task automatic test_r0();
    int q;
    do_cmd(OP_ADD, 0, 0, 0, 1, 3, 0, q);
    checks++;
    if (RspData !== 3'b011 || RspRd !== 3'd0) begin
      errors++; $display("FAIL r0_write_rsp: data %0d rd %0d want 3 0", RspData, RspRd);
    end
    do_cmd(OP_PASSA, 0, 0, 1, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'b000) begin
      errors++; $display("FAIL r0_reads_zero: got %0d want 0", RspData);
    end
  endtask

  task automatic test_reset_exec();
    int q;
    do_cmd(OP_ADD, 0, 0, 1, 1, 6, 0, q);
    @(negedge Clk);
    CmdValid = 1'b1; CmdOp = 3'd1; CmdRa = 3'd1; CmdRd = 3'd1; CmdImmEn = 1'b1; CmdImm = 3'd1;
    @(negedge Clk);
    CmdValid = 1'b0;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b1) begin
      errors++; $display("FAIL exec_reset_now: valid %b ready %b want 0 1", RspValid, CmdReady);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    clear_model();
    @(negedge Clk);
    checks++;
    if (RspValid !== 1'b0 || CmdReady !== 1'b1) begin
      errors++; $display("FAIL exec_reset_after: valid %b ready %b want 0 1", RspValid, CmdReady);
    end
    do_cmd(OP_PASSA, 1, 0, 0, 0, 0, 0, q);
    checks++;
    if (RspData !== 3'd0) begin
      errors++; $display("FAIL exec_reset_r1: got %0d want 0", RspData);
    end
  endtask

  task automatic test_random();
    int q;
    for (int n = 0; n < 150; n++) begin
      do_cmd($urandom_range(0, 7), $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
             $urandom_range(0, NREGS - 1), $urandom_range(0, 1), $urandom_range(0, MODV - 1),
             $urandom_range(0, 3), q);
    end
    for (int i = 0; i < NREGS; i++) begin
      do_cmd(OP_PASSA, i, 0, 0, 0, 0, 0, q);
      checks++;
      if (RspData !== 3'(mrf[i])) begin
        errors++; $display("FAIL rand_final_r%0d: got %0d want %0d", i, RspData, mrf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_r0();
    test_reset_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
